// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } rf_state_t;

    localparam int RF_CNT_W = 32;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks every writable entry to zero, then pulses done.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          wr_ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);
    localparam logic [AW-1:0] FIRST = AW'(ZERO_REG != 0 ? 1 : 0);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    idx_d   = FIRST;
                end
            end
            SWEEP: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign clr_busy = (state_q != IDLE);
    assign clr_done = (state_q == DONE);
    assign wr_ready = (state_q == IDLE);
    assign clr_we   = (state_q == SWEEP);
    assign clr_idx  = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with bypass, clear sweep
// and an accepted-write counter.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NWR-1:0]                  wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]             wr_data,
    output logic                            wr_ready,
    input  logic [NRD*$clog2(NREGS)-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]             rd_data,
    input  logic [$clog2(NREGS)-1:0]        dbg_sel,
    output logic [XLEN-1:0]                 dbg_data,
    input  logic                            clr_req,
    output logic                            clr_busy,
    output logic                            clr_done,
    output logic [RF_CNT_W-1:0]             wr_count
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     mem_q [NREGS];
    logic [AW-1:0]       waddr [NWR];
    logic [XLEN-1:0]     wdata [NWR];
    logic [NWR-1:0]      acc;
    logic                clr_we;
    logic [AW-1:0]       clr_idx;
    logic [RF_CNT_W-1:0] cnt_q, cnt_d, inc;

    regfile_clr_fsm #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .wr_ready (wr_ready),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    for (genvar p = 0; p < NWR; p++) begin : g_wr
        assign waddr[p] = wr_addr[p*AW +: AW];
        assign wdata[p] = wr_data[p*XLEN +: XLEN];
    end

    always_comb begin
        acc = '0;
        for (int p = 0; p < NWR; p++) begin
            acc[p] = wr_en[p] && wr_ready &&
                     !((ZERO_REG != 0) && (waddr[p] == '0));
        end
    end

    // Ascending port order: the highest-index port's write lands last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            if (clr_we) mem_q[clr_idx] <= '0;
            for (int p = 0; p < NWR; p++) begin
                if (acc[p]) mem_q[waddr[p]] <= wdata[p];
            end
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] v;
        assign ra = rd_addr[r*AW +: AW];
        always_comb begin
            v = mem_q[ra];
            if (BYPASS != 0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (acc[p] && (waddr[p] == ra)) v = wdata[p];
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) v = '0;
        end
        assign rd_data[r*XLEN +: XLEN] = v;
    end

    assign dbg_data = ((ZERO_REG != 0) && (dbg_sel == '0)) ?
                      '0 : mem_q[dbg_sel];

    always_comb begin
        inc = '0;
        for (int p = 0; p < NWR; p++) begin
            inc = inc + RF_CNT_W'(acc[p]);
        end
        cnt_d = cnt_q + inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign wr_count = cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: writes, zero reg, collision, bypass,
// clear sweep and reset during a sweep.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        wr_en;
    logic [2*AW-1:0]   wr_addr;
    logic [2*XLEN-1:0] wr_data;
    logic              wr_ready;
    logic [2*AW-1:0]   rd_addr;
    logic [2*XLEN-1:0] rd_data;
    logic [AW-1:0]     dbg_sel;
    logic [XLEN-1:0]   dbg_data;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;
    logic [31:0]       wr_count;

    int checks = 0;
    int errors = 0;

    regfile_mp #(
        .XLEN(32), .NREGS(32), .NRD(2), .NWR(2),
        .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a,
                          input logic [XLEN-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    initial begin
        int busy_n;
        int done_n;
        int done_at;
        logic [31:0] acc_or;

        rst_n = 1'b0;
        wr_en = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        dbg_sel = '0;
        clr_req = 1'b0;
        #12;
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_busy", 32'(clr_busy), 32'd0);
        chk("rst_done", 32'(clr_done), 32'd0);
        chk("rst_count", wr_count, 32'd0);
        dbg_sel = 5'd5;
        #1 chk("rst_x5", dbg_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // write x5 via port 0
        @(negedge clk);
        set_wr(0, 5'd5, 32'hDEADBEEF);
        rd_addr[0 +: AW] = 5'd5;
        #1 chk("x5_bypass", rd_data[31:0], 32'hDEADBEEF);
        @(negedge clk);
        wr_en = '0;
        #1;
        chk("x5_read", rd_data[31:0], 32'hDEADBEEF);
        chk("x5_count", wr_count, 32'd1);
        chk("x5_dbg", dbg_data, 32'hDEADBEEF);

        // zero register write is dropped
        set_wr(0, 5'd0, 32'h1234);
        rd_addr[0 +: AW] = 5'd0;
        dbg_sel = 5'd0;
        #1 chk("x0_bypass", rd_data[31:0], 32'd0);
        @(negedge clk);
        wr_en = '0;
        #1;
        chk("x0_read", rd_data[31:0], 32'd0);
        chk("x0_dbg", dbg_data, 32'd0);
        chk("x0_count", wr_count, 32'd1);

        // collision on x7
        set_wr(0, 5'd7, 32'hAAAA);
        set_wr(1, 5'd7, 32'h5555);
        rd_addr[AW +: AW] = 5'd7;
        #1 chk("coll_bypass", rd_data[63:32], 32'h5555);
        @(negedge clk);
        wr_en = '0;
        dbg_sel = 5'd7;
        #1;
        chk("coll_store", dbg_data, 32'h5555);
        chk("coll_count", wr_count, 32'd3);

        // bypass vs. debug on x3
        set_wr(1, 5'd3, 32'h11);
        @(negedge clk);
        wr_en = '0;
        set_wr(0, 5'd3, 32'h77);
        rd_addr[0 +: AW] = 5'd3;
        dbg_sel = 5'd3;
        #1;
        chk("byp_rd", rd_data[31:0], 32'h77);
        chk("byp_dbg_old", dbg_data, 32'h11);
        @(negedge clk);
        wr_en = '0;
        #1;
        chk("byp_dbg_new", dbg_data, 32'h77);
        chk("byp_count", wr_count, 32'd5);

        // fill x1..x31 with 0x100+i
        for (int i = 1; i < NREGS; i++) begin
            set_wr(0, AW'(i), 32'h100 + 32'(i));
            @(negedge clk);
        end
        wr_en = '0;
        dbg_sel = 5'd31;
        #1;
        chk("fill_x31", dbg_data, 32'h11F);
        chk("fill_count", wr_count, 32'd36);

        // clear sweep
        clr_req = 1'b1;
        rd_addr[0 +: AW] = 5'd4;
        busy_n = 0;
        done_n = 0;
        done_at = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) begin
                clr_req = 1'b0;
                set_wr(0, 5'd4, 32'hFFFF);
                set_wr(1, 5'd9, 32'hEEEE);
                #1 chk("sweep_rd_nobyp", rd_data[31:0], 32'h104);
                chk("sweep_ready", 32'(wr_ready), 32'd0);
            end
            #1;
            if (!clr_busy) break;
            busy_n++;
            if (clr_done) begin
                done_n++;
                done_at = c - 1;
            end
        end
        wr_en = '0;
        chk("sweep_busy_cycles", 32'(busy_n), 32'd32);
        chk("sweep_done_pulses", 32'(done_n), 32'd1);
        chk("sweep_done_at", 32'(done_at), 32'd31);
        chk("sweep_ready_back", 32'(wr_ready), 32'd1);
        chk("sweep_count", wr_count, 32'd36);
        acc_or = '0;
        for (int i = 0; i < NREGS; i++) begin
            dbg_sel = AW'(i);
            #1 acc_or = acc_or | dbg_data;
        end
        chk("sweep_all_zero", acc_or, 32'd0);

        // reset during a sweep
        @(negedge clk);
        set_wr(0, 5'd31, 32'h31);
        @(negedge clk);
        wr_en = '0;
        clr_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            clr_req = 1'b0;
        end
        dbg_sel = 5'd31;
        #1;
        chk("mid_partial_x31", dbg_data, 32'h31);
        chk("mid_busy", 32'(clr_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(clr_busy), 32'd0);
        chk("mid_rst_done", 32'(clr_done), 32'd0);
        chk("mid_rst_x31", dbg_data, 32'd0);
        chk("mid_rst_count", wr_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1 if (clr_done || clr_busy) done_n++;
        end
        chk("mid_no_done", 32'(done_n), 32'd0);
        chk("mid_ready", 32'(wr_ready), 32'd1);
        acc_or = '0;
        for (int i = 0; i < NREGS; i++) begin
            dbg_sel = AW'(i);
            #1 acc_or = acc_or | dbg_data;
        end
        chk("mid_all_zero", acc_or, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the single-cycle and follow-on pipelined cores. It sits between decode/writeback and the ALU operand muxes. It generalises the current 32x32, 2-read/1-write file in five ways: configurable width, depth, read-port count and write-port count; optional hardwired zero register; optional write-to-read bypass; a hardware clear sequencer; and an accepted-write counter for debug visibility.

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of entries; power of two, ≥2. AW = $clog2(NREGS).
- NRD, 2: read ports, ≥1.
- NWR, 2: write ports, ≥1.
- ZERO_REG, 1: when 1, entry 0 reads as 0 and writes to it are dropped.
- BYPASS, 1: when 1, same-cycle write data is forwarded to matching read ports.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses; port p uses slice p.
- wr_data  in  NWR*XLEN  write data.
- wr_ready  out  1  high when writes are accepted; equals state==IDLE.
- rd_addr  in  NRD*AW  read addresses.
- rd_data  out  NRD*XLEN  combinational read data.
- dbg_sel  in  AW  debug read address.
- dbg_data  out  XLEN  combinational debug read; never bypassed.
- clr_req  in  1  request a full clear sweep.
- clr_busy  out  1  high while state != IDLE.
- clr_done  out  1  one-cycle pulse when the sweep completes.
- wr_count  out  32  count of accepted writes; wraps modulo 2^32.

## Operation
- Reset (rst_n low, asynchronous):
  - All entries go to 0 and state goes to IDLE.
  - wr_count = 0, clr_busy = 0, clr_done = 0, wr_ready = 1.
- A write is accepted on port p when all of the following hold:
  - wr_en[p] = 1;
  - state == IDLE;
  - not (ZERO_REG and wr_addr[p] == 0).
- Multiple accepted writes to the same address in one cycle: the highest-index port wins; the others are discarded.
- wr_count increments by the number of accepted writes in the cycle (0..NWR), including writes that lose the collision.
- Read port r returns, in priority order:
  - 0 if ZERO_REG and rd_addr[r] == 0;
  - otherwise, if BYPASS and an accepted write targets rd_addr[r] this cycle, that write's data (highest-index port on collision);
  - otherwise the stored entry.
- Clear sequencer states are IDLE, SWEEP and DONE:
  - IDLE → SWEEP when clr_req = 1. idx is loaded with ZERO_REG ? 1 : 0.
  - In SWEEP, entry[idx] is set to 0 each cycle and idx increments. After idx == NREGS-1 is cleared, the state moves to DONE.
  - DONE → IDLE unconditionally; clr_done = 1 only in DONE.
  - clr_req is ignored in SWEEP and DONE; it is not queued.
- During SWEEP and DONE:
  - all write ports are ignored and do not count;
  - no bypass occurs;
  - reads return current array contents, which may be partially cleared.
- If rst_n is asserted mid-sweep, the sweep aborts; after rst_n deasserts the state is IDLE with all entries 0.

## Timing
- Write latency is 1 cycle: data written at edge k is visible via the array from edge k onward. With BYPASS = 1 it is visible combinationally in the same cycle.
- Clear sweep: clr_req is sampled at edge k, and clr_busy rises after edge k.
- Entries are cleared at edges k+1 … k+M, where M = NREGS − ZERO_REG.
- clr_done is high for the cycle between edges k+M and k+M+1. wr_ready returns after edge k+M+1.
- All outputs other than the combinational reads are registered or decoded directly from state.

## Structure
- regfile_pkg holds:
  - the state enum `rf_state_t` (IDLE, SWEEP, DONE);
  - the counter width constant `RF_CNT_W = 32`.
- The sub-module regfile_clr_fsm contains the state, idx and clr_busy/clr_done/wr_ready logic. It exports clr_we and clr_idx to the array.
- The top level contains the array, write-port priority merge, bypass muxes, debug port and wr_count.

## Test plan
- **Reset and write:** reset, then write 0xDEADBEEF to x5 via port 0. The next cycle rd_data[0] with rd_addr = 5 reads 0xDEADBEEF, and wr_count = 1.
- **Zero register:** with ZERO_REG = 1, write 0x1234 to x0. rd_data reads 0, dbg_data reads 0, and wr_count is unchanged.
- **Write collision:** port 0 writes 0xAAAA and port 1 writes 0x5555 to x7 in the same cycle. The stored value is 0x5555, the same-cycle bypass read also returns 0x5555, and wr_count increases by 2.
- **Bypass:** with BYPASS = 1, write 0x77 to x3 while reading x3 in the same cycle; the read returns 0x77 combinationally. dbg_sel = 3 returns the old value until the edge.
- **Clear sweep:** fill x1..x31 with nonzero values, then pulse clr_req with NREGS = 32 and ZERO_REG = 1.
  - clr_busy stays high for 32 cycles and clr_done pulses exactly once, 31 cycles after clr_req.
  - Writes issued during the sweep are dropped and not counted.
  - All entries read 0 afterward.
- **Reset mid-sweep:** assert rst_n low at sweep cycle 10. clr_busy goes to 0 immediately, with no clr_done pulse, and all entries read 0.
